// File: rtl/i2c_rx_byte_ctrl.sv
// I2C slave receive sequencer: START/STOP detection, MSB-first byte shift, ACK drive, valid/ready hand-off.
// Optional build macro I2C_ADDR_MATCH_EN: NACK the first byte after START unless its upper 7 bits equal SLAVE_ADDR.
module i2c_rx_byte_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter logic [6:0]  SLAVE_ADDR = 7'h50
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_first,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned       CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  BYTE_BITS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK, NACK} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                first_q, first_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_first_q, rx_first_d;
  logic                sda_oe_q, sda_oe_d;
  logic                overrun_q, overrun_d;
  logic                scl_q, sda_q;

  logic scl_rise, scl_fall, start_det, stop_det, addr_ok;

  assign scl_rise  = !scl_q & scl_in;
  assign scl_fall  = scl_q & !scl_in;
  // Our own ACK pull-down must never be mistaken for bus conditions.
  assign start_det = scl_q & scl_in & sda_q & !sda_in & !sda_oe_q;
  assign stop_det  = scl_q & scl_in & !sda_q & sda_in & !sda_oe_q;

`ifdef I2C_ADDR_MATCH_EN
  assign addr_ok = !first_q || (shreg_q[DATA_W-1 -: 7] == SLAVE_ADDR);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    first_d    = first_q;
    rx_valid_d = rx_valid_q;
    rx_first_d = rx_first_q;
    sda_oe_d   = sda_oe_q;
    overrun_d  = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      first_d   = 1'b1;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (bit_cnt_q != BYTE_BITS) begin
            if (scl_rise) begin
              shreg_d   = {shreg_q[DATA_W-2:0], sda_in};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (scl_fall) begin
            if (!addr_ok) begin
              state_d = NACK;
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shreg_q;
              rx_first_d = first_q;
              rx_valid_d = 1'b1;
              first_d    = 1'b0;
              sda_oe_d   = 1'b1;
              state_d    = ACK;
            end else begin
              overrun_d = 1'b1;
              state_d   = NACK;
            end
          end
        end
        ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        NACK: begin
          if (scl_fall) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      first_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      overrun_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      first_q    <= first_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      sda_oe_q   <= sda_oe_d;
      overrun_q  <= overrun_d;
      scl_q      <= scl_in;
      sda_q      <= sda_in;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2c_rx_byte_ctrl.sv
// Randomized bench for i2c_rx_byte_ctrl: bit-level I2C master driver plus a byte-level
// queue model of what the consumer should see, what gets ACKed and how many overruns occur.
module tb_i2c_rx_byte_ctrl;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       rx_ready = 1'b0;
  logic       sda_in;
  logic       sda_oe, rx_valid, rx_first, busy, overrun;
  logic [7:0] rx_data;

  // Open-drain bus: either side may pull SDA low.
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_rx_byte_ctrl #(.DATA_W(8), .SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst_(rst_), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_first(rx_first),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic       first;
    logic [7:0] data;
  } rec_t;

  rec_t       exp_q[$];
  logic       first_pending = 1'b0;
  logic [7:0] last_loaded = 8'h00;
  int         n_checks = 0, n_errors = 0;
  int         n_pushed = 0, n_deliv = 0, exp_ovr = 0, ovr_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer side: every handshake must match the oldest byte the model accepted.
  always @(negedge clk) begin
    rec_t r;
    if (rst_) begin
      if (overrun) ovr_cycles++;
      if (rx_valid && rx_ready) begin
        n_deliv++;
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check_eq("rx_data", rx_data, r.data);
          check_eq("rx_first", rx_first, r.first);
        end
      end
    end
  end

  task automatic m_start();
    if (!scl) begin
      wait_clk(4); sda_drv = 1'b1;
      wait_clk(4); scl = 1'b1;
      wait_clk(4);
    end
    sda_drv = 1'b0;
    wait_clk(8); scl = 1'b0;
    first_pending = 1'b1;
  endtask

  task automatic m_stop();
    wait_clk(4); sda_drv = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); sda_drv = 1'b1;
    wait_clk(6);
  endtask

  task automatic m_bit_high(input logic b);
    wait_clk(4); sda_drv = b;
    wait_clk(4); scl = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_partial(input int k);
    for (int i = 0; i < k; i++) begin
      m_bit_high(1'($urandom_range(0, 1)));
      scl = 1'b0;
    end
  endtask

  // Full byte plus ACK slot; do_rst pulls reset in the middle of the ACK high phase.
  task automatic send_byte(input logic [7:0] b, input logic rdy, input bit do_rst, output logic acked);
    logic exp_ack;
    rx_ready = rdy;
    for (int i = 7; i >= 0; i--) begin
      m_bit_high(b[i]);
      if (i != 0) scl = 1'b0;
    end
`ifdef I2C_ADDR_MATCH_EN
    if (first_pending && b[7:1] != 7'h50) exp_ack = 1'b0;
    else
`endif
    if (exp_q.size() == 0 || rx_ready) begin
      exp_ack = 1'b1;
      exp_q.push_back('{first_pending, b});
      n_pushed++;
      last_loaded = b;
      first_pending = 1'b0;
    end else begin
      exp_ack = 1'b0;
      exp_ovr++;
    end
    scl = 1'b0;
    wait_clk(4); sda_drv = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(4);
    check_eq("ack_slot", sda_oe, exp_ack);
    acked = exp_ack;
    if (do_rst) begin
      check_eq("valid_before_rst", rx_valid, exp_q.size() != 0);
      rst_ = 1'b0;
      #1;
      check_eq("rst_sda_oe", sda_oe, 0);
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rx_data", rx_data, 0);
      exp_q.delete();
      n_pushed = n_deliv;
      last_loaded = 8'h00;
      first_pending = 1'b0;
      wait_clk(3);
      rst_ = 1'b1;
      wait_clk(3);
    end else begin
      wait_clk(4); scl = 1'b0;
      wait_clk(2);
      check_eq("busy_after_byte", busy, exp_ack);
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    wait_clk(4);
    rx_ready = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
`ifdef I2C_ADDR_MATCH_EN
    if (first_pending && $urandom_range(0, 3) != 0) b = {7'h50, 1'($urandom_range(0, 1))};
`endif
    return b;
  endfunction

  initial begin
    logic ack;
    int   nb;

    #1 rst_ = 1'b0;
    wait_clk(3);
    check_eq("reset_sda_oe", sda_oe, 0);
    check_eq("reset_rx_data", rx_data, 0);
    check_eq("reset_rx_valid", rx_valid, 0);
    check_eq("reset_rx_first", rx_first, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_overrun", overrun, 0);
    rst_ = 1'b1;
    wait_clk(3);

    // Single byte with consumer ready.
    m_start(); check_eq("busy_start", busy, 1);
    send_byte(8'hA5, 1'b1, 1'b0, ack);
    m_stop(); check_eq("busy_stop", busy, 0);

    // Second byte arrives while the first is still pending.
    m_start();
    send_byte(8'h12, 1'b0, 1'b0, ack);
    if (ack) send_byte(8'h34, 1'b0, 1'b0, ack);
    check_eq("hold_valid", rx_valid, exp_q.size() != 0);
    check_eq("hold_data", rx_data, last_loaded);
    m_stop();
    drain();

    // Repeated START between bytes.
    m_start();
    send_byte(8'h11, 1'b1, 1'b0, ack);
    m_start();
    send_byte(8'h22, 1'b1, 1'b0, ack);
    m_stop();

    // STOP mid-byte discards the partial byte.
    m_start();
    send_partial(4);
    m_stop();
    m_start();
    send_byte(8'h3C, 1'b1, 1'b0, ack);
    m_stop();

`ifdef I2C_ADDR_MATCH_EN
    m_start(); send_byte(8'hA0, 1'b1, 1'b0, ack); m_stop();
    m_start(); send_byte(8'hA2, 1'b1, 1'b0, ack); m_stop();
`endif

    // Reset during the ACK high phase, then a fresh byte.
    drain();
    m_start();
    send_byte(8'hA0, 1'b0, 1'b1, ack);
    m_start();
    send_byte(8'h5A, 1'b1, 1'b0, ack);
    m_stop();

    for (int t = 0; t < 40; t++) begin
      m_start();
      check_eq("busy_rand_start", busy, 1);
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 9) == 0) begin
          send_partial($urandom_range(1, 7));
          break;
        end
        send_byte(pick_byte(), 1'($urandom_range(0, 2) != 0), 1'b0, ack);
        if (!ack) break;
      end
      if ($urandom_range(0, 3) != 0) begin
        m_stop();
        check_eq("busy_rand_stop", busy, 0);
      end
    end
    if (!scl) m_stop();

    drain();
    wait_clk(2);
    check_eq("deliveries", n_deliv, n_pushed);
    check_eq("overrun_cycles", ovr_cycles, exp_ovr);
    check_eq("final_valid", rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_rx_byte_ctrl.md
Name: i2c_rx_byte_ctrl

Overview:
Bit-level sequencer for the I2C slave receive path. It detects START/STOP on pre-synchronized SCL/SDA and shifts 8 data bits MSB-first into an internal shift register. It drives the ACK slot and hands each completed byte to the register-file side over a valid/ready handshake. It sits between the pad synchronizers and the slave register block.

Parameters:
DATA_W, 8, bits per I2C byte; fixed at 8 for compliant operation.
SLAVE_ADDR, 7'h50, 7-bit slave address; used only when I2C_ADDR_MATCH_EN is defined.

Ports:
clk  input  1  system clock, at least 8x SCL frequency
rst_  input  1  reset, asynchronous, active-low
scl_in  input  1  SCL, already synchronized to clk
sda_in  input  1  SDA, already synchronized to clk
sda_oe  output  1  1 = pull SDA low (ACK); 0 = release
rx_data  output  DATA_W  received byte
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready
rx_first  output  1  rx_data is the first byte after a START or repeated START
busy  output  1  transaction in progress (state != IDLE)
overrun  output  1  one-cycle pulse: a byte was NACKed because rx_valid was still set

Behaviour:
- Reset: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, busy=0, overrun=0; state=IDLE; bit_cnt=0; shift register=0; scl_q=1, sda_q=1.
- Edge detection uses registered scl_q/sda_q:
  - scl_rise = !scl_q & scl_in; scl_fall = scl_q & !scl_in.
  - START = scl_q & scl_in & sda_q & !sda_in.
  - STOP = scl_q & scl_in & !sda_q & sda_in.
- States: IDLE, SHIFT, ACK, NACK.
- IDLE: ignore all activity except START. START -> SHIFT, bit_cnt=0, first_flag=1.
- SHIFT, on scl_rise: shreg <= {shreg[DATA_W-2:0], sda_in}; bit_cnt++.
  - After the 8th rise, wait for the next scl_fall.
  - At that scl_fall:
    - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data<=shreg and rx_first<=first_flag, set rx_valid=1, clear first_flag, sda_oe=1, -> ACK.
    - Otherwise: overrun pulses for 1 cycle, sda_oe stays 0, rx_data is unchanged, -> NACK.
- ACK: hold sda_oe=1 through the 9th SCL high phase. On the next scl_fall: sda_oe=0, bit_cnt=0, -> SHIFT.
- NACK: on the next scl_fall -> IDLE. The master is expected to issue STOP or repeated START.
- START in any non-IDLE state (repeated START): -> SHIFT, bit_cnt=0, first_flag=1, sda_oe=0. A pending rx_valid byte is kept.
- STOP in any state: -> IDLE, sda_oe=0, bit_cnt=0. A pending rx_valid byte is kept.
- START/STOP detection is ignored while sda_oe=1.
- Handshake: rx_valid stays high and rx_data/rx_first stay stable until the rx_valid & rx_ready cycle. rx_valid clears on that cycle unless a new byte loads in the same cycle, in which case it stays 1 with the new data.
- Latency: rx_valid rises 1 clk after the scl_fall that ends bit 8.
- Async reset mid-byte discards the partial byte and any pending rx_data.

Optional Feature:
I2C_ADDR_MATCH_EN
- Defined: the first byte after a START is an address byte.
  - If shreg[7:1]==SLAVE_ADDR: ACK and deliver it with rx_first=1.
  - If it mismatches: no ACK, no delivery, no overrun pulse, -> NACK (and then IDLE until the next START).
- Not defined: every byte is ACKed and delivered, subject only to the overrun rule. SLAVE_ADDR is unused.

Test Plan:
- START, bits 0xA5, rx_ready=1 -> sda_oe=1 during the 9th SCL pulse; rx_data=0xA5, rx_first=1, rx_valid for 1 cycle; busy=1 until STOP.
- START, 0x12, 0x34, rx_ready=0 until the second byte completes -> byte 2 is NACKed (sda_oe=0), overrun=1 for 1 cycle, rx_data stays 0x12, state returns to IDLE.
- START, 0x11, repeated START, 0x22 -> second delivery shows rx_first=1 and rx_data=0x22.
- STOP after 4 bits, then START + 0x3C -> the partial byte is discarded and rx_data=0x3C.
- Reset asserted mid-ACK -> sda_oe, rx_valid and busy go to 0 immediately; after release, a fresh byte 0x5A is received normally.
- With I2C_ADDR_MATCH_EN and SLAVE_ADDR=7'h50:
  - First byte 0xA0 -> ACK, rx_data=0xA0, rx_first=1.
  - First byte 0xA2 -> NACK, no rx_valid, no overrun.
